// File: rtl/pipe_flow_ctrl_if.sv
// Bundle between the hazard/branch logic and the pipeline sequencing controller.
// No storage; pure signal grouping.
// Flow control is level-based enables; no handshake is carried here.
interface pipe_flow_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             branch_valid;
  logic             use_npc;
  logic             load_use_hazard;
  logic             halt_detected;
  logic             step_mode;
  logic             step_pulse;
  logic             pc_write;
  logic             pc_sel_target;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             back_enable;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [15:0]      flush_count;

  // Hazard/branch/debug side
  modport master (
    output branch_valid, use_npc, load_use_hazard, halt_detected, step_mode, step_pulse,
    input  pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_flush,
    input  back_enable, halted, cycle_count, flush_count
  );

  // Controller side
  modport slave (
    input  branch_valid, use_npc, load_use_hazard, halt_detected, step_mode, step_pulse,
    output pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_flush,
    output back_enable, halted, cycle_count, flush_count
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Sequencing controller for the 5-stage pipeline: PC/stage enables, flushes, halt drain, single-step.
// Control outputs are combinational from state and inputs; state and counters update on the next edge.
// In step mode the whole pipeline freezes until step_pulse; HALT drains the back end then stops.
module pipe_flow_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic           clk,
  input logic           reset,
  pipe_flow_ctrl_if.slave bus
);

  // A zero drain length still needs one cycle in DRAIN to reach HALTED.
  localparam int DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int DW         = $clog2(DRAIN_LOAD + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DRAIN_LOAD[DW-1:0];

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_WAIT = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    drain_cnt, drain_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [15:0]      flush_cnt;

  logic advance;
  logic taken;
  logic pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_flush;
  logic back_enable, halted;

  // Next state and control outputs; reset overrides every output to 0.
  always_comb begin
    state_nxt     = state;
    drain_nxt     = drain_cnt;
    taken         = 1'b0;
    pc_write      = 1'b0;
    pc_sel_target = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    back_enable   = 1'b0;
    halted        = 1'b0;
    advance       = (state == RUN) || ((state == STEP_WAIT) && bus.step_pulse);

    case (state)
      RUN, STEP_WAIT: begin
        if (advance) begin
          back_enable = 1'b1;
          if (bus.halt_detected) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (bus.branch_valid && !bus.use_npc) begin
            // Taken branch wins over a load-use stall: the stalled instruction is wrong-path.
            taken         = 1'b1;
            pc_write      = 1'b1;
            pc_sel_target = 1'b1;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
          end else if (bus.load_use_hazard) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        if (advance && bus.halt_detected) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_INIT;
        end else begin
          state_nxt = bus.step_mode ? STEP_WAIT : RUN;
        end
      end
      DRAIN: begin
        back_enable = 1'b1;
        drain_nxt   = drain_cnt - DW'(1);
        if (drain_cnt <= DW'(1)) begin
          state_nxt = HALTED;
        end
      end
      default: begin
        halted = 1'b1;
      end
    endcase

    if (reset) begin
      taken         = 1'b0;
      pc_write      = 1'b0;
      pc_sel_target = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      back_enable   = 1'b0;
      halted        = 1'b0;
    end
  end

  // State, drain counter and debug counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= bus.step_mode ? STEP_WAIT : RUN;
      drain_cnt <= '0;
      cycle_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (back_enable) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (taken && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_sel_target = pc_sel_target;
  assign bus.if_id_write   = if_id_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.back_enable   = back_enable;
  assign bus.halted        = halted;
  assign bus.cycle_count   = cycle_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: directed scenarios plus random stimulus against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// The model tracks mode as plain flags and a remaining-drain count.
module tb_pipe_flow_ctrl;
  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  pipe_flow_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_flow_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic pc_write;
    logic pc_sel_target;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic back_enable;
    logic halted;
  } ctl_t;

  // Behavioural model state
  bit          m_known    = 0;
  bit          m_stepping = 0;
  bit          m_halted   = 0;
  int          m_drain    = 0;
  logic [31:0] m_cyc      = '0;
  int          m_flush    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t expect_ctl();
    ctl_t e;
    bit   go;
    e  = '0;
    go = !m_stepping || bus.step_pulse;
    if (reset) return e;
    if (m_halted) begin
      e.halted = 1'b1;
    end else if (m_drain > 0) begin
      e.back_enable = 1'b1;
    end else if (go) begin
      e.back_enable = 1'b1;
      if (bus.halt_detected) begin
        e.if_id_flush = 1'b1;
        e.id_ex_flush = 1'b1;
      end else if (bus.branch_valid && !bus.use_npc) begin
        e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      end else if (bus.load_use_hazard) begin
        e.id_ex_flush = 1'b1;
      end else begin
        e.pc_write    = 1'b1;
        e.if_id_write = 1'b1;
      end
    end
    return e;
  endfunction

  // Advance the model at each rising edge using the inputs held over the cycle.
  always @(posedge clk) begin
    ctl_t e;
    bit   go;
    e  = expect_ctl();
    go = !m_stepping || bus.step_pulse;
    if (reset) begin
      m_known    = 1;
      m_stepping = bus.step_mode;
      m_halted   = 0;
      m_drain    = 0;
      m_cyc      = '0;
      m_flush    = 0;
    end else if (m_known) begin
      if (e.back_enable) m_cyc = m_cyc + 32'd1;
      if (e.pc_sel_target && m_flush < 65535) m_flush = m_flush + 1;
      if (m_halted) begin
      end else if (m_drain > 0) begin
        if (m_drain == 1) m_halted = 1;
        m_drain = m_drain - 1;
      end else if (go && bus.halt_detected) begin
        m_drain = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
      end else begin
        m_stepping = bus.step_mode;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    ctl_t e;
    if (m_known) begin
      e = expect_ctl();
      chk("pc_write",      32'(bus.pc_write),      32'(e.pc_write));
      chk("pc_sel_target", 32'(bus.pc_sel_target), 32'(e.pc_sel_target));
      chk("if_id_write",   32'(bus.if_id_write),   32'(e.if_id_write));
      chk("if_id_flush",   32'(bus.if_id_flush),   32'(e.if_id_flush));
      chk("id_ex_flush",   32'(bus.id_ex_flush),   32'(e.id_ex_flush));
      chk("back_enable",   32'(bus.back_enable),   32'(e.back_enable));
      chk("halted",        32'(bus.halted),        32'(e.halted));
      chk("cycle_count",   bus.cycle_count,        m_cyc);
      chk("flush_count",   32'(bus.flush_count),   32'(m_flush));
    end
  end

  // One cycle of stimulus; returns with combinational outputs settled.
  task automatic tick(input logic r, input logic bv, input logic npc, input logic luh,
                      input logic hd, input logic sm, input logic sp);
    @(posedge clk);
    #1;
    reset               = r;
    bus.branch_valid    = bv;
    bus.use_npc         = npc;
    bus.load_use_hazard = luh;
    bus.halt_detected   = hd;
    bus.step_mode       = sm;
    bus.step_pulse      = sp;
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    bus.branch_valid    = 1'b0;
    bus.use_npc         = 1'b1;
    bus.load_use_hazard = 1'b0;
    bus.halt_detected   = 1'b0;
    bus.step_mode       = 1'b0;
    bus.step_pulse      = 1'b0;

    // Reset, then idle run
    tick(1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 0, 0);
    chk("reset_pc_write", 32'(bus.pc_write), 32'd0);
    chk("reset_halted",   32'(bus.halted),   32'd0);
    repeat (5) tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("idle_cycle_count", bus.cycle_count, 32'd5);
    chk("idle_pc_write",    32'(bus.pc_write), 32'd1);

    // Taken branch overrides load-use hazard
    tick(0, 1, 0, 1, 0, 0, 0);
    chk("taken_sel",   32'(bus.pc_sel_target), 32'd1);
    chk("taken_ifid",  32'(bus.if_id_flush),   32'd1);
    chk("taken_idex",  32'(bus.id_ex_flush),   32'd1);
    chk("taken_pcw",   32'(bus.pc_write),      32'd1);
    chk("taken_fc0",   32'(bus.flush_count),   32'd0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("taken_fc1",   32'(bus.flush_count),   32'd1);

    // Not-taken branch with hazard stalls
    tick(0, 1, 1, 1, 0, 0, 0);
    chk("stall_pcw",   32'(bus.pc_write),    32'd0);
    chk("stall_ifw",   32'(bus.if_id_write), 32'd0);
    chk("stall_idex",  32'(bus.id_ex_flush), 32'd1);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("post_stall_pcw", 32'(bus.pc_write), 32'd1);

    // HALT: two drain cycles then halted, inputs ignored
    tick(0, 0, 1, 0, 1, 0, 0);
    chk("halt_be",     32'(bus.back_enable), 32'd1);
    chk("halt_pcw",    32'(bus.pc_write),    32'd0);
    tick(0, 1, 0, 1, 0, 1, 1);
    chk("drain1_be",   32'(bus.back_enable), 32'd1);
    chk("drain1_sel",  32'(bus.pc_sel_target), 32'd0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("drain2_be",   32'(bus.back_enable), 32'd1);
    tick(0, 1, 0, 1, 0, 0, 0);
    chk("halted",      32'(bus.halted),      32'd1);
    chk("halted_be",   32'(bus.back_enable), 32'd0);
    chk("halted_pcw",  32'(bus.pc_write),    32'd0);
    tick(1, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("rerun_pcw",   32'(bus.pc_write),    32'd1);

    // Single-step
    tick(1, 0, 1, 0, 0, 1, 0);
    repeat (3) begin
      tick(0, 0, 1, 0, 0, 1, 0);
      chk("frozen_be", 32'(bus.back_enable), 32'd0);
    end
    tick(0, 0, 1, 0, 0, 1, 1);
    chk("step_pcw",    32'(bus.pc_write),    32'd1);
    tick(0, 0, 1, 0, 0, 1, 0);
    chk("refrozen_be", 32'(bus.back_enable), 32'd0);
    chk("step_cycles", bus.cycle_count,      32'd1);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("leave_step_frozen", 32'(bus.pc_write), 32'd0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("back_to_run", 32'(bus.pc_write), 32'd1);

    // Random traffic with occasional reset, halt and step-mode changes
    begin
      logic sm;
      sm = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) sm = ~sm;
        tick(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 39) == 0), sm, 1'($urandom));
      end
    end

    // flush_count saturation
    tick(1, 0, 1, 0, 0, 0, 0);
    repeat (65535) tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("fc_full", 32'(bus.flush_count), 32'h0000FFFF);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("fc_sat",  32'(bus.flush_count), 32'h0000FFFF);

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
